// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, framing constants and the
// frame builder used by the transmitter (and later the receiver).
package uart_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    TX_STATE = 1'b1
  } uart_state_t;

  localparam int BAUD_DIV_115K2 = 434;
  localparam int FRAME_BITS     = 10;

  // 8N1 frame, LSB first on the wire: start (0), data[0..7], stop (1).
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data);
    return {1'b1, data, 1'b0};
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Core-side handshake of the UART transmitter: byte strobe, done flag and
// the serial line itself. The core drives through 'master', uart_tx is 'slave'.
interface uart_tx_if;

  logic       trmt;
  logic [7:0] tx_data;
  logic       clr_done;
  logic       TX;
  logic       tx_rdy;
  logic       tx_done;
  logic       busy;

  modport master (
    output trmt, tx_data, clr_done,
    input  TX, tx_rdy, tx_done, busy
  );

  modport slave (
    input  trmt, tx_data, clr_done,
    output TX, tx_rdy, tx_done, busy
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: a reloadable down-counter that pulses o_bit_tick on the
// last clock of every bit, then reloads itself so bits stay exactly BAUD_DIV long.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_115K2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_bit_tick
);

  localparam int               CNT_W  = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_bit_tick = i_en && (r_cnt == '0);

  // Reload takes priority over the decrement, so the counter never wraps below 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load || o_bit_tick) begin
      r_cnt <= RELOAD;
    end else if (i_en) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register, so a queued byte
// follows the previous stop bit with no idle gap on TX.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_115K2
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus
);

  uart_state_t           r_state;
  uart_state_t           w_state_next;
  logic [7:0]            r_hold;
  logic                  r_hold_full;
  logic [FRAME_BITS-1:0] r_shift;
  logic [3:0]            r_bit_cnt;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_tx_done;

  logic w_accept;
  logic w_en;
  logic w_bit_tick;
  logic w_last_bit;
  logic w_load;
  logic w_shift;
  logic w_frame_end;
  logic w_tx_next;

  // A strobe is taken only while the holding register is empty, even if the
  // shifter happens to drain it on the same edge.
  assign w_accept   = bus.trmt && !r_hold_full;
  assign w_en       = (r_state == TX_STATE);
  assign w_last_bit = (r_bit_cnt == 4'(FRAME_BITS - 1));

  uart_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_gen (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_en       (w_en),
    .o_bit_tick (w_bit_tick)
  );

  // NOTE: state lives in always_ff with non-blocking assignments so every
  // register samples the pre-edge values of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: each always_comb assigns a default to every output first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (r_hold_full) w_state_next = TX_STATE;
      TX_STATE: if (w_frame_end && !r_hold_full) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_frame_end = 1'b0;
    w_tx_next   = 1'b1;
    case (r_state)
      IDLE: begin
        w_load = r_hold_full;
      end
      TX_STATE: begin
        w_tx_next = r_shift[0];
        if (w_bit_tick) begin
          w_shift = 1'b1;
          if (w_last_bit) begin
            w_frame_end = 1'b1;
            w_load      = r_hold_full;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  // NOTE: pure data registers carry no reset; they are only ever observed
  // behind r_hold_full or TX_STATE, both of which are reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hold <= bus.tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_load) begin
      r_shift <= make_frame(r_hold);
    end else if (w_shift) begin
      r_shift <= {1'b1, r_shift[FRAME_BITS-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
    end else if (w_load) begin
      r_bit_cnt <= '0;
    end else if (w_shift) begin
      r_bit_cnt <= r_bit_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
    end else if (w_load) begin
      r_busy <= 1'b1;
    end else if (w_frame_end) begin
      r_busy <= 1'b0;
    end
  end

  // Clearing has priority, so a clr_done on the frame-end edge leaves done low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_done <= 1'b0;
    end else if (w_accept || bus.clr_done) begin
      r_tx_done <= 1'b0;
    end else if (w_frame_end) begin
      r_tx_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx <= 1'b1;
    end else begin
      r_tx <= w_tx_next;
    end
  end

  assign bus.TX      = r_tx;
  assign bus.tx_rdy  = !r_hold_full;
  assign bus.tx_done = r_tx_done;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a BAUD_DIV=8 instance for framing, hold and done
// behaviour, and a default-divisor instance for exact 115k2 bit timing.
module tb_uart_tx;

  localparam int DIV_F = 8;
  localparam int DIV_S = 434;
  localparam int LOG_N = 8192;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  int n_checks = 0;
  int n_pass   = 0;

  logic tx_f_log   [LOG_N];
  logic busy_f_log [LOG_N];
  logic done_f_log [LOG_N];
  logic rdy_f_log  [LOG_N];
  logic tx_s_log   [LOG_N];
  logic busy_s_log [LOG_N];

  uart_tx_if if_f ();
  uart_tx_if if_s ();

  uart_tx #(.BAUD_DIV(DIV_F)) u_dut_fast (.clk(clk), .rst(rst), .bus(if_f));
  uart_tx #(.BAUD_DIV(DIV_S)) u_dut_slow (.clk(clk), .rst(rst), .bus(if_s));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Entry k holds the outputs as they stand after posedge number k.
  always @(negedge clk) begin
    if (cyc < LOG_N) begin
      tx_f_log[cyc]   <= if_f.TX;
      busy_f_log[cyc] <= if_f.busy;
      done_f_log[cyc] <= if_f.tx_done;
      rdy_f_log[cyc]  <= if_f.tx_rdy;
      tx_s_log[cyc]   <= if_s.TX;
      busy_s_log[cyc] <= if_s.busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  // Present trmt/tx_data so that posedge number e samples them.
  task automatic pulse_trmt(input bit slow, input int e, input logic [7:0] d, output logic rdy_seen);
    wait_cyc(e - 1);
    if (slow) begin
      rdy_seen = if_s.tx_rdy;
      if_s.trmt = 1'b1; if_s.tx_data = d;
    end else begin
      rdy_seen = if_f.tx_rdy;
      if_f.trmt = 1'b1; if_f.tx_data = d;
    end
    @(negedge clk);
    if_f.trmt = 1'b0;
    if_s.trmt = 1'b0;
  endtask

  task automatic pulse_clr(input int e);
    wait_cyc(e - 1);
    if_f.clr_done = 1'b1;
    @(negedge clk);
    if_f.clr_done = 1'b0;
  endtask

  function automatic logic tx_at(input bit slow, input int k);
    return slow ? tx_s_log[k] : tx_f_log[k];
  endfunction

  // Frame whose trmt was taken at edge n: bit j occupies cycles
  // [n+2+div*j, n+2+div*(j+1)); a bit that wobbles inside its slot reads as x.
  task automatic check_frame(input string tag, input int n, input logic [7:0] d,
                             input int div, input bit slow);
    logic [9:0] f;
    logic [7:0] rx;
    logic       obs;
    int         s;
    f = {1'b1, d, 1'b0};
    for (int j = 0; j < 10; j++) begin
      s   = n + 2 + div * j;
      obs = tx_at(slow, s);
      for (int c = s + 1; c < s + div; c++)
        if (tx_at(slow, c) !== obs) obs = 1'bx;
      check($sformatf("%s bit%0d", tag, j), {31'd0, obs}, {31'd0, f[j]});
    end
    for (int j = 1; j <= 8; j++)
      rx[j-1] = tx_at(slow, n + 2 + div * j + div / 2);
    check($sformatf("%s decode", tag), {24'd0, rx}, {24'd0, d});
  endtask

  initial begin
    int   n, m, p, q, r, rr, s, cnt;
    logic rdy;

    if_f.trmt = 1'b0; if_f.tx_data = 8'h00; if_f.clr_done = 1'b0;
    if_s.trmt = 1'b0; if_s.tx_data = 8'h00; if_s.clr_done = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst TX",      {31'd0, if_f.TX},      32'd1);
    check("rst tx_rdy",  {31'd0, if_f.tx_rdy},  32'd1);
    check("rst busy",    {31'd0, if_f.busy},    32'd0);
    check("rst tx_done", {31'd0, if_f.tx_done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single byte 0xA5
    n = cyc + 3;
    pulse_trmt(0, n, 8'hA5, rdy);
    check("a5 rdy at strobe", {31'd0, rdy}, 32'd1);
    wait_cyc(n + 100);
    check_frame("a5", n, 8'hA5, DIV_F, 0);
    check("a5 done before end", {31'd0, done_f_log[n+80]}, 32'd0);
    check("a5 done at end",     {31'd0, done_f_log[n+81]}, 32'd1);
    check("a5 busy before",     {31'd0, busy_f_log[n]},    32'd0);
    check("a5 busy load",       {31'd0, busy_f_log[n+1]},  32'd1);
    check("a5 busy last",       {31'd0, busy_f_log[n+80]}, 32'd1);
    check("a5 busy after",      {31'd0, busy_f_log[n+81]}, 32'd0);
    check("a5 rdy accepted",    {31'd0, rdy_f_log[n]},     32'd0);
    check("a5 rdy drained",     {31'd0, rdy_f_log[n+1]},   32'd1);

    // trmt clears done; clr_done on the frame-end edge beats the set
    m = cyc + 2;
    pulse_trmt(0, m, 8'h3C, rdy);
    pulse_clr(m + 81);
    wait_cyc(m + 100);
    check("trmt clears done pre",  {31'd0, done_f_log[m-1]},  32'd1);
    check("trmt clears done post", {31'd0, done_f_log[m]},    32'd0);
    check("clr wins at end",       {31'd0, done_f_log[m+81]}, 32'd0);
    check("clr wins after",        {31'd0, done_f_log[m+82]}, 32'd0);
    check_frame("3c", m, 8'h3C, DIV_F, 0);

    // Back-to-back 0x00 then 0xFF
    p = cyc + 2;
    pulse_trmt(0, p, 8'h00, rdy);
    pulse_trmt(0, p + 30, 8'hFF, rdy);
    check("b2b second rdy", {31'd0, rdy}, 32'd1);
    wait_cyc(p + 180);
    check("b2b rdy held",    {31'd0, rdy_f_log[p+30]}, 32'd0);
    check("b2b rdy pending", {31'd0, rdy_f_log[p+80]}, 32'd0);
    check("b2b rdy reload",  {31'd0, rdy_f_log[p+81]}, 32'd1);
    check("b2b done first",  {31'd0, done_f_log[p+81]}, 32'd1);
    check_frame("00", p, 8'h00, DIV_F, 0);
    check_frame("ff", p + 80, 8'hFF, DIV_F, 0);
    cnt = 0;
    for (int k = p + 1; k < p + 161; k++) if (busy_f_log[k] !== 1'b1) cnt++;
    check("b2b busy gaps", cnt, 32'd0);
    check("b2b busy end", {31'd0, busy_f_log[p+161]}, 32'd0);

    // Overrun: 0x33 mid-frame and 0x44 on the reload edge are both dropped
    q = cyc + 2;
    pulse_trmt(0, q, 8'h11, rdy);
    pulse_trmt(0, q + 20, 8'h22, rdy);
    check("ovr 22 rdy", {31'd0, rdy}, 32'd1);
    pulse_trmt(0, q + 40, 8'h33, rdy);
    check("ovr 33 rdy", {31'd0, rdy}, 32'd0);
    pulse_trmt(0, q + 81, 8'h44, rdy);
    check("ovr 44 rdy", {31'd0, rdy}, 32'd0);
    wait_cyc(q + 200);
    check_frame("11", q, 8'h11, DIV_F, 0);
    check_frame("22", q + 80, 8'h22, DIV_F, 0);
    check("ovr rdy after reload", {31'd0, rdy_f_log[q+82]}, 32'd1);
    cnt = 0;
    for (int k = q + 162; k < q + 200; k++)
      if (tx_f_log[k] !== 1'b1 || busy_f_log[k] !== 1'b0) cnt++;
    check("ovr idle after 22", cnt, 32'd0);

    // Reset while idle with tx_done set
    check("idle done pre-rst", {31'd0, if_f.tx_done}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("idle rst TX",      {31'd0, if_f.TX},      32'd1);
    check("idle rst tx_rdy",  {31'd0, if_f.tx_rdy},  32'd1);
    check("idle rst busy",    {31'd0, if_f.busy},    32'd0);
    check("idle rst tx_done", {31'd0, if_f.tx_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset during a start bit with a second byte held
    r = cyc + 2;
    pulse_trmt(0, r, 8'h0F, rdy);
    pulse_trmt(0, r + 3, 8'hF0, rdy);
    wait_cyc(r + 5);
    check("frame TX pre-rst",  {31'd0, if_f.TX},     32'd0);
    check("frame rdy pre-rst", {31'd0, if_f.tx_rdy}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("frame rst TX",      {31'd0, if_f.TX},      32'd1);
    check("frame rst tx_rdy",  {31'd0, if_f.tx_rdy},  32'd1);
    check("frame rst busy",    {31'd0, if_f.busy},    32'd0);
    check("frame rst tx_done", {31'd0, if_f.tx_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rr = cyc;
    wait_cyc(rr + 120);
    cnt = 0;
    for (int k = rr + 1; k < rr + 120; k++)
      if (tx_f_log[k] !== 1'b1 || busy_f_log[k] !== 1'b0) cnt++;
    check("frame rst discards", cnt, 32'd0);

    // 115k2 divisor, byte 0x55
    s = cyc + 2;
    pulse_trmt(1, s, 8'h55, rdy);
    wait_cyc(s + 4400);
    check_frame("55 slow", s, 8'h55, DIV_S, 1);
    check("slow busy last", {31'd0, busy_s_log[s+4340]}, 32'd1);
    check("slow busy end",  {31'd0, busy_s_log[s+4341]}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
